// File: rtl/screen_erase_sequencer.sv
// Sequencer that blanks regions of a ring-buffered text screen and scrolls it.
// One command at a time: optional scroll-origin update, then a run of space writes.
module screen_erase_sequencer #(
    parameter int ROWS      = 24,
    parameter int COLS      = 80,
    parameter int ROW_BITS  = 5,
    parameter int COL_BITS  = 7,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           cmd,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [COL_BITS-1:0]  cursor_x,
    input  logic [ROW_BITS-1:0]  cursor_y,
    input  logic [ADDR_BITS-1:0] first_char,
    output logic [7:0]           new_char,
    output logic [ADDR_BITS-1:0] new_char_address,
    output logic                 new_char_wen,
    output logic [ADDR_BITS-1:0] new_first_char,
    output logic                 new_first_char_wen,
    output logic                 done,
    output logic                 busy
);

    localparam int N  = ROWS * COLS;
    localparam int AW = ADDR_BITS + 1;
    localparam logic [AW-1:0]        N_W       = AW'(N);
    localparam logic [AW-1:0]        COLS_W    = AW'(COLS);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N - 1);
    localparam logic [7:0]           BLANK     = 8'h20;

    typedef enum logic [1:0] {IDLE, SCROLL, FILL, DONE} state_t;

    state_t               state;
    logic [AW-1:0]        remaining;
    logic [ADDR_BITS-1:0] fill_start;

    logic                 in_range;
    logic [AW-1:0]        pos;
    logic [AW-1:0]        base_mod;
    logic [AW-1:0]        sum_raw;
    logic [AW-1:0]        origin_raw;
    logic [ADDR_BITS-1:0] start_calc;
    logic [ADDR_BITS-1:0] scroll_origin;
    logic [AW-1:0]        count_calc;

    // Every sum stays below 2N, so a single conditional subtract keeps it inside the ring.
    always_comb begin
        in_range      = (cursor_x < COL_BITS'(COLS)) && (cursor_y < ROW_BITS'(ROWS));
        pos           = AW'(cursor_y) * COLS_W + AW'(cursor_x);
        base_mod      = ({1'b0, first_char} >= N_W) ? ({1'b0, first_char} - N_W) : {1'b0, first_char};
        sum_raw       = base_mod + pos;
        origin_raw    = base_mod + COLS_W;
        scroll_origin = ADDR_BITS'((origin_raw >= N_W) ? (origin_raw - N_W) : origin_raw);
        start_calc    = ADDR_BITS'(base_mod);
        count_calc    = '0;
        case (cmd)
            2'd0: begin
                start_calc = ADDR_BITS'((sum_raw >= N_W) ? (sum_raw - N_W) : sum_raw);
                count_calc = in_range ? (COLS_W - AW'(cursor_x)) : '0;
            end
            2'd1: begin
                start_calc = ADDR_BITS'((sum_raw >= N_W) ? (sum_raw - N_W) : sum_raw);
                count_calc = in_range ? (N_W - pos) : '0;
            end
            2'd2:    count_calc = N_W;
            default: count_calc = COLS_W;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            remaining          <= '0;
            fill_start         <= '0;
            new_char           <= '0;
            new_char_address   <= '0;
            new_char_wen       <= 1'b0;
            new_first_char     <= '0;
            new_first_char_wen <= 1'b0;
            done               <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid) begin
                        if (cmd == 2'd3) begin
                            state              <= SCROLL;
                            new_first_char     <= scroll_origin;
                            new_first_char_wen <= 1'b1;
                            fill_start         <= start_calc;
                            remaining          <= count_calc;
                        end else if (count_calc == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state            <= FILL;
                            new_char         <= BLANK;
                            new_char_address <= start_calc;
                            new_char_wen     <= 1'b1;
                            remaining        <= count_calc;
                        end
                    end
                end
                SCROLL: begin
                    state              <= FILL;
                    new_first_char_wen <= 1'b0;
                    new_char           <= BLANK;
                    new_char_address   <= fill_start;
                    new_char_wen       <= 1'b1;
                end
                FILL: begin
                    // remaining counts the write currently on the outputs, so 1 means last.
                    if (remaining == AW'(1)) begin
                        state        <= DONE;
                        new_char_wen <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        remaining        <= remaining - AW'(1);
                        new_char_address <= (new_char_address == LAST_ADDR) ? '0
                                            : new_char_address + ADDR_BITS'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = !cmd_ready;

endmodule

// File: tb/tb_screen_erase_sequencer.sv
// Bench for screen_erase_sequencer: fixed vector table, random commands against a
// per-cycle trace model, and hand-written busy/abort sequences.
module tb_screen_erase_sequencer;

    localparam int ROWS = 24;
    localparam int COLS = 80;
    localparam int N    = ROWS * COLS;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [10:0] first_char;
    logic [7:0]  new_char;
    logic [10:0] new_char_address;
    logic        new_char_wen;
    logic [10:0] new_first_char;
    logic        new_first_char_wen;
    logic        done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cmd;
        int x;
        int y;
        int fc;
        int expWrites;
        int expFirst;
        int expDone;
    } vec_t;

    vec_t vecs[8];

    screen_erase_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .cmd                (cmd),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cursor_x           (cursor_x),
        .cursor_y           (cursor_y),
        .first_char         (first_char),
        .new_char           (new_char),
        .new_char_address   (new_char_address),
        .new_char_wen       (new_char_wen),
        .new_first_char     (new_first_char),
        .new_first_char_wen (new_first_char_wen),
        .done               (done),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One word per cycle: ready, busy, done, strobes, and the data fields only while strobed.
    function automatic longint packSig(input bit r, input bit b, input bit d, input bit fw,
                                       input bit w, input int ch, input int addr, input int fca);
        longint s;
        s = 0;
        if (fw) s = s | longint'(fca & 'hfff);
        if (w)  s = s | (longint'(addr & 'hfff) << 12) | (longint'(ch & 'hff) << 24);
        s = s | (longint'(w) << 32) | (longint'(fw) << 33) | (longint'(d) << 34)
              | (longint'(b) << 35) | (longint'(r) << 36);
        return s;
    endfunction

    function automatic longint actualSig();
        return packSig(cmd_ready, busy, done, new_first_char_wen, new_char_wen,
                       int'(new_char), int'(new_char_address), int'(new_first_char));
    endfunction

    // Reference model: what the command means on the screen, in plain arithmetic.
    task automatic computeJob(input int c, input int x, input int y, input int fc,
                              output int start, output int count, output bit scroll);
        int  p;
        bit  valid;
        p      = y * COLS + x;
        valid  = (x < COLS) && (y < ROWS);
        scroll = (c == 3);
        case (c)
            0: begin start = (fc + p) % N; count = valid ? COLS - x : 0; end
            1: begin start = (fc + p) % N; count = valid ? N - p : 0; end
            2: begin start = fc; count = N; end
            default: begin start = fc; count = COLS; end
        endcase
    endtask

    function automatic longint expectedSig(input int i, input int start, input int count,
                                           input int fc, input bit scroll);
        int doneIdx;
        int wi;
        bit fw;
        bit w;
        bit d;
        bit b;
        doneIdx = scroll ? count + 2 : count + 1;
        wi      = scroll ? i - 2 : i - 1;
        fw      = scroll && (i == 1);
        w       = (wi >= 0) && (wi < count);
        d       = (i == doneIdx);
        b       = (i <= doneIdx);
        return packSig(!b, b, d, fw, w, 'h20, (start + (wi < 0 ? 0 : wi)) % N, (fc + COLS) % N);
    endfunction

    task automatic applyStimulus(input int c, input int x, input int y, input int fc);
        cmd        = 2'(c);
        cursor_x   = 7'(x);
        cursor_y   = 5'(y);
        first_char = 11'(fc);
        cmd_valid  = 1'b1;
    endtask

    // Issues one command and compares every cycle from accept through the return to idle.
    task automatic runCommand(input int c, input int x, input int y, input int fc, input string tag,
                              output int writes, output int firstAddr, output int doneCycle);
        int  n;
        int  start;
        int  count;
        bit  scroll;
        int  last;
        writes    = 0;
        firstAddr = -1;
        doneCycle = -1;
        n         = 0;
        while (!cmd_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checkOutput({tag, " ready timeout"}, 0, 1);
            return;
        end
        computeJob(c, x, y, fc, start, count, scroll);
        applyStimulus(c, x, y, fc);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        last = (scroll ? count + 2 : count + 1) + 1;
        for (int i = 1; i <= last; i++) begin
            checkOutput($sformatf("%s cyc %0d", tag, i), actualSig(),
                        expectedSig(i, start, count, fc, scroll));
            if (new_char_wen) begin
                if (writes == 0) firstAddr = int'(new_char_address);
                writes++;
            end
            if (done && doneCycle < 0) doneCycle = i;
            if (i < last) @(negedge clk);
        end
    endtask

    initial begin
        int writes;
        int firstAddr;
        int doneCycle;
        int c;
        int seenBad;

        vecs[0] = '{0, 75,  2,    0,    5,  235,    6};
        vecs[1] = '{2,  0,  0, 1900, 1920, 1900, 1921};
        vecs[2] = '{3,  0,  0, 1840,   80, 1840,   82};
        vecs[3] = '{0, 80,  0,    5,    0,   -1,    1};
        vecs[4] = '{1,  0, 23,  100,   80,   20,   81};
        vecs[5] = '{1,  3, 24,   50,    0,   -1,    1};
        vecs[6] = '{0, 79, 23, 1919,    1, 1918,    2};
        vecs[7] = '{1,  0,  0,    7, 1920,    7, 1921};

        reset      = 1'b1;
        cmd        = 2'd0;
        cmd_valid  = 1'b0;
        cursor_x   = '0;
        cursor_y   = '0;
        first_char = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset wen",       new_char_wen,       0);
        checkOutput("reset fc wen",    new_first_char_wen, 0);
        checkOutput("reset done",      done,               0);
        checkOutput("reset char",      new_char,           0);
        checkOutput("reset addr",      new_char_address,   0);
        checkOutput("reset fc",        new_first_char,     0);
        checkOutput("reset cmd_ready", cmd_ready,          1);
        checkOutput("reset busy",      busy,               0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            runCommand(vecs[v].cmd, vecs[v].x, vecs[v].y, vecs[v].fc,
                       $sformatf("vec%0d", v), writes, firstAddr, doneCycle);
            checkOutput($sformatf("vec%0d writes", v), writes, vecs[v].expWrites);
            if (vecs[v].expWrites > 0)
                checkOutput($sformatf("vec%0d first addr", v), firstAddr, vecs[v].expFirst);
            checkOutput($sformatf("vec%0d done cycle", v), doneCycle, vecs[v].expDone);
        end

        for (int r = 0; r < 24; r++) begin
            c = $urandom_range(0, 3);
            if (c == 2 && (r % 3) != 0) c = 3;
            runCommand(c, $urandom_range(0, 85), $urandom_range(0, 26), $urandom_range(0, N - 1),
                       $sformatf("rand%0d", r), writes, firstAddr, doneCycle);
        end

        // cmd_valid held high for the whole fill must not start anything before idle.
        applyStimulus(1, 0, 22, 0);
        @(posedge clk);
        @(negedge clk);
        writes    = 0;
        doneCycle = -1;
        for (int i = 1; i <= 162; i++) begin
            if (new_char_wen) writes++;
            if (done && doneCycle < 0) doneCycle = i;
            if (i < 162) @(negedge clk);
        end
        checkOutput("held valid writes", writes, 160);
        checkOutput("held valid done cycle", doneCycle, 161);
        checkOutput("held valid idle ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("held valid reaccept", {busy, new_char_wen, new_char_address}, {2'b11, 11'd1760});
        cmd_valid = 1'b0;
        repeat (40) @(negedge clk);

        // Mid-fill reset: strobes drop without waiting for a clock edge.
        #2 reset = 1'b1;
        #1;
        checkOutput("abort wen",  new_char_wen, 0);
        checkOutput("abort busy", busy,         0);
        checkOutput("abort ready", cmd_ready,   1);
        seenBad = 0;
        @(posedge clk);
        @(negedge clk);
        if (new_char_wen || done || new_first_char_wen) seenBad = 1;
        checkOutput("abort quiet", seenBad, 0);
        reset = 1'b0;
        runCommand(0, 75, 2, 0, "post-reset", writes, firstAddr, doneCycle);
        checkOutput("post-reset writes", writes, 5);
        checkOutput("post-reset first addr", firstAddr, 235);

        runCommand(0, 80, 0, 0, "invalid", writes, firstAddr, doneCycle);
        checkOutput("invalid writes", writes, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/screen_erase_sequencer.md
SCREEN_ERASE_SEQUENCER -- requirements
Module: screen_erase_sequencer

Interface
REQ-001 Parameters SHALL be:
  ROWS, 24, text rows
  COLS, 80, text columns
  ROW_BITS, 5, cursor row width
  COL_BITS, 7, cursor column width
  ADDR_BITS, 11, char buffer address width
  N = ROWS*COLS (1920), derived, ring size of the char buffer.
REQ-002 Ports SHALL be:
  clk  in  1  single clock; all logic in this domain
  reset  in  1  asynchronous, active-high reset
  cmd  in  2  0=erase to end of line, 1=erase to end of screen, 2=clear screen, 3=scroll up one line
  cmd_valid  in  1  command request
  cmd_ready  out  1  sequencer idle, command accepted this cycle if cmd_valid
  cursor_x  in  COL_BITS  cursor column, sampled at accept
  cursor_y  in  ROW_BITS  cursor row, sampled at accept
  first_char  in  ADDR_BITS  current top-left buffer address, sampled at accept
  new_char  out  8  data to char buffer
  new_char_address  out  ADDR_BITS  char buffer write address
  new_char_wen  out  1  char buffer write strobe
  new_first_char  out  ADDR_BITS  new scroll origin
  new_first_char_wen  out  1  scroll register write strobe
  done  out  1  one-cycle completion pulse
  busy  out  1  high whenever state is not IDLE

Function
REQ-003 States SHALL be IDLE, SCROLL, FILL, DONE; cmd_ready SHALL equal (state==IDLE); busy SHALL equal !cmd_ready.
REQ-004 Accept SHALL occur on a rising edge with cmd_valid && cmd_ready; cmd, cursor_x, cursor_y, first_char captured on that edge; cmd_valid while busy SHALL be ignored, never queued.
REQ-005 At accept, with p = cursor_y*COLS + cursor_x and all address sums modulo N: cmd 0 -> start=(first_char+p), count=COLS-cursor_x; cmd 1 -> start=(first_char+p), count=N-p; cmd 2 -> start=first_char, count=N; cmd 3 -> start=first_char, count=COLS.
REQ-006 For cmd 0/1, cursor_x>=COLS or cursor_y>=ROWS SHALL give count=0.
REQ-007 Transitions: IDLE->SCROLL on cmd 3; IDLE->FILL on cmd 0..2 with count>0; IDLE->DONE on count=0; SCROLL->FILL after one cycle; FILL->DONE after the last write; DONE->IDLE after one cycle.
REQ-008 In SCROLL, new_first_char_wen SHALL be high exactly one cycle with new_first_char=(first_char+COLS) mod N.
REQ-009 In FILL, new_char_wen SHALL be high every cycle, new_char=8'h20, address starting at start and incrementing by 1 per cycle, wrapping N-1 -> 0; exactly count writes SHALL occur.
REQ-010 Latency: accept at edge k; first write (or scroll strobe) visible in cycle k+1; for cmd 0..2, done high in cycle k+1+count; for cmd 3, done high in cycle k+2+COLS; for count=0, done high in cycle k+1.
REQ-011 done SHALL be high exactly one cycle per accepted command, only in DONE; new_char_wen and new_first_char_wen SHALL never be high in the same cycle.
REQ-012 All outputs SHALL be registered; address arithmetic SHALL never present an address >= N.

Reset
REQ-013 reset SHALL force, asynchronously, state=IDLE, new_char_wen=0, new_first_char_wen=0, done=0, new_char=0, new_char_address=0, new_first_char=0; cmd_ready=1, busy=0.
REQ-014 reset asserted mid-FILL or mid-SCROLL SHALL abort without further writes or done pulse; first accept is possible on the first edge after release.

Verification
REQ-015 Reset: assert reset -> all strobes 0, addresses 0, cmd_ready=1, busy=0.
REQ-016 EOL: first_char=0, x=75, y=2, cmd=0 -> 5 writes of 0x20 to 235..239, done one cycle after the last write.
REQ-017 Clear with wrap: first_char=1900, cmd=2 -> 1920 consecutive writes, addresses 1900..1919 then 0..1899, done at k+1921.
REQ-018 Scroll wrap: first_char=1840, cmd=3 -> new_first_char=0 with wen for one cycle, then 80 writes to 1840..1919, done at k+82.
REQ-019 Busy/abort: cmd_valid held high through a cmd=1 fill -> no second accept until IDLE; reset pulse mid-fill -> wen drops immediately, no done.
REQ-020 Invalid cursor: x=80, y=0, cmd=0 -> zero writes, done at k+1, cmd_ready back at k+2.
